// File: rtl/cbus_arbiter_pkg.sv
// cbus_arbiter_pkg: shared cbus request/response types used by the arbiter and its neighbours
package cbus_arbiter_pkg;
  localparam int CBUS_ADDR_W = 64;
  localparam int CBUS_DATA_W = 64;
  localparam int CBUS_STRB_W = CBUS_DATA_W / 8;
  typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef enum logic [3:0] {MLEN1 = 4'd0, MLEN2 = 4'd1, MLEN4 = 4'd3, MLEN8 = 4'd7, MLEN16 = 4'd15} mlen_t;
  typedef enum logic [1:0] {AXI_BURST_FIXED, AXI_BURST_INCR, AXI_BURST_WRAP} axi_burst_type_t;
  typedef struct packed {
    logic valid;
    logic is_write;
    msize_t size;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_STRB_W-1:0] strobe;
    logic [CBUS_DATA_W-1:0] data;
    mlen_t len;
    axi_burst_type_t burst;
  } cbus_req_t;
  typedef struct packed {
    logic ready;
    logic last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;
endpackage

// File: rtl/cbus_arb_select.sv
// cbus_arb_select: picks the next winner from the valid vector; CBUS_ARB_RR_EN selects round-robin instead of fixed priority
module cbus_arb_select #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W = 1
) (
  input logic [NUM_REQ-1:0] valid,
`ifdef CBUS_ARB_RR_EN
  input logic [IDX_W-1:0] ptr,
`endif
  output logic [IDX_W-1:0] winner,
  output logic any_valid
);
  always_comb begin
    winner = '0;
    any_valid = |valid;
`ifdef CBUS_ARB_RR_EN
    // descending scan so the candidate closest after ptr is assigned last and wins
    for (int k = NUM_REQ; k >= 1; k--)
      if (valid[(int'(ptr) + k) % NUM_REQ]) winner = IDX_W'((int'(ptr) + k) % NUM_REQ);
`else
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (valid[i]) winner = IDX_W'(i);
`endif
  end
endmodule

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: grants the shared cbus to one requester per transaction (index 0 fetch, 1 data)
// CBUS_ARB_RR_EN builds round-robin selection; default is fixed priority
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input logic clk,
  input logic reset,
  input cbus_req_t ireqs [NUM_REQ],
  output cbus_resp_t iresps [NUM_REQ],
  output cbus_req_t oreq,
  input cbus_resp_t oresp,
  output logic busy
);
  localparam int IDX_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [IDX_W-1:0] grant, winner;
  logic [NUM_REQ-1:0] valid;
  logic any_valid;
  always_comb begin
    valid = '0;
    for (int i = 0; i < NUM_REQ; i++) valid[i] = ireqs[i].valid;
  end
`ifdef CBUS_ARB_RR_EN
  logic [IDX_W-1:0] ptr;
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= IDX_W'(NUM_REQ - 1);
    else if (state == IDLE && any_valid) ptr <= winner;
`endif
  cbus_arb_select #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_select (
    .valid(valid),
`ifdef CBUS_ARB_RR_EN
    .ptr(ptr),
`endif
    .winner(winner),
    .any_valid(any_valid)
  );
  // only the index is latched; payload is forwarded live, so requesters must hold it stable
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      busy <= 1'b0;
    end else if (state == IDLE) begin
      if (any_valid) begin
        state <= BUSY;
        grant <= winner;
        busy <= 1'b1;
      end
    end else if (oresp.ready && oresp.last) begin
      state <= IDLE;
      busy <= 1'b0;
    end
  always_comb begin
    oreq = state == BUSY ? ireqs[grant] : '0;
    for (int i = 0; i < NUM_REQ; i++) iresps[i] = state == BUSY && grant == IDX_W'(i) ? oresp : '0;
  end
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: vector table, directed corner cases and randomized run against a transaction-level model
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;
  localparam int N = 2;
  typedef struct {
    logic v0, v1, rdy, lst;
    int g;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  cbus_req_t ireqs [N];
  cbus_resp_t iresps [N];
  cbus_req_t oreq;
  cbus_resp_t oresp;
  logic busy;
  cbus_req_t req_base [N];
  vec_t tbl[$];
  int order[$];
  int checks = 0, fails = 0;
  int mown = -1, mptr = N - 1;
  always #5 clk = ~clk;
  cbus_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps),
    .oreq(oreq), .oresp(oresp), .busy(busy)
  );
  function automatic int pick();
    int best = -1;
`ifdef CBUS_ARB_RR_EN
    for (int k = 1; k <= N; k++)
      if (best < 0 && ireqs[(mptr + k) % N].valid) best = (mptr + k) % N;
`else
    for (int i = 0; i < N; i++)
      if (best < 0 && ireqs[i].valid) best = i;
`endif
    return best;
  endfunction
  // owner of the bus: -1 when free; one free cycle always precedes each new owner
  always @(posedge clk or posedge reset)
    if (reset) begin
      mown <= -1;
      mptr <= N - 1;
    end else if (mown < 0) begin
      mown <= pick();
      if (pick() >= 0) mptr <= pick();
    end else if (oresp.ready && oresp.last) mown <= -1;
  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_cycle(input string tag, input int g);
    cbus_req_t er;
    er = '0;
    if (g >= 0) er = ireqs[g];
    chk({tag, ".oreq"}, 192'(oreq), 192'(er));
    for (int i = 0; i < N; i++)
      chk($sformatf("%s.iresp%0d", tag, i), 192'(iresps[i]), g == i ? 192'(oresp) : 192'(0));
    chk({tag, ".busy"}, 192'(busy), 192'(g >= 0));
  endtask
  task automatic drive(input logic v0, input logic v1);
    ireqs[0] = req_base[0];
    ireqs[0].valid = v0;
    ireqs[1] = req_base[1];
    ireqs[1].valid = v1;
  endtask
  task automatic add(input logic v0, input logic v1, input logic rdy, input logic lst, input int g);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.rdy = rdy; v.lst = lst; v.g = g;
    tbl.push_back(v);
  endtask
  initial begin
    req_base[0] = '{valid: 1'b1, is_write: 1'b0, size: MSIZE4, addr: 64'h1000, strobe: 8'h0f,
                    data: 64'h0, len: MLEN1, burst: AXI_BURST_INCR};
    req_base[1] = '{valid: 1'b1, is_write: 1'b1, size: MSIZE8, addr: 64'h2000, strobe: 8'hff,
                    data: 64'hdead_beef, len: MLEN4, burst: AXI_BURST_INCR};
    // two requesters together, single beat: 0 first, turnaround, then 1
    add(1,1,0,0,-1); add(1,1,0,0,0); add(1,1,0,0,0); add(1,1,1,1,0);
    add(0,1,0,0,-1); add(0,1,0,0,1); add(0,1,1,1,1); add(0,0,0,0,-1);
    // four-beat burst from 1, ready every other cycle
    add(0,1,0,0,-1); add(0,1,1,0,1); add(0,1,0,0,1); add(0,1,1,0,1);
    add(0,1,0,0,1); add(0,1,1,0,1); add(0,1,0,0,1); add(0,1,1,1,1);
    // requester 0 arrives mid-burst: no preemption
    add(0,1,0,0,-1); add(0,1,0,0,1); add(1,1,1,0,1); add(1,1,0,0,1);
    add(1,1,1,1,1); add(1,0,0,0,-1); add(1,0,0,0,0); add(1,0,1,1,0);
    // withdrawal: grant held until downstream last
    add(0,0,0,0,-1); add(0,1,0,0,-1); add(0,1,0,0,1); add(0,0,0,0,1);
    add(0,0,1,1,1); add(0,0,0,0,-1);
    drive(0, 0);
    oresp = '{ready: 1'b1, last: 1'b1, data: 64'h55};
    #1 check_cycle("reset", -1);
    @(negedge clk);
    reset = 1'b0;
    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].v0, tbl[k].v1);
      oresp = '{ready: tbl[k].rdy, last: tbl[k].lst, data: 64'hd000 + 64'(k)};
      #1 check_cycle($sformatf("vec%0d", k), tbl[k].g);
    end
    // asynchronous reset in the middle of a grant
    @(negedge clk);
    drive(0, 1);
    oresp = '{ready: 1'b0, last: 1'b0, data: 64'h0};
    @(negedge clk);
    #1 chk("rst.pre_addr", 192'(oreq.addr), 192'(64'h2000));
    oresp = '{ready: 1'b1, last: 1'b0, data: 64'h77};
    #1 reset = 1'b1;
    #1 check_cycle("rst.async", -1);
    @(negedge clk);
    reset = 1'b0;
    #1 check_cycle("rst.release", -1);
    @(posedge clk);
    #1 chk("rst.regrant_addr", 192'(oreq.addr), 192'(64'h2000));
    chk("rst.regrant_busy", 192'(busy), 192'(1));
    @(negedge clk);
    oresp = '{ready: 1'b1, last: 1'b1, data: 64'h0};
    drive(0, 0);
    @(negedge clk);
    oresp = '0;
    // both permanently valid, six single-beat transactions
    @(negedge clk);
    reset = 1'b1;
    #1 reset = 1'b0;
    drive(1, 1);
    oresp = '{ready: 1'b1, last: 1'b1, data: 64'h9};
    for (int c = 0; c < 40 && order.size() < 6; c++) begin
      @(negedge clk);
      #1 if (oreq.valid) order.push_back(oreq.addr == 64'h2000 ? 1 : 0);
    end
    chk("order.count", 192'(order.size()), 192'(6));
    for (int j = 0; j < 6; j++) begin
`ifdef CBUS_ARB_RR_EN
      chk($sformatf("order%0d", j), 192'(j < order.size() ? order[j] : 99), 192'(j % 2));
`else
      chk($sformatf("order%0d", j), 192'(j < order.size() ? order[j] : 99), 192'(0));
`endif
    end
    // randomized traffic against the model
    @(negedge clk);
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        ireqs[i].valid = $urandom_range(0, 3) != 0;
        ireqs[i].addr = {$urandom, $urandom};
        ireqs[i].data = {$urandom, $urandom};
        ireqs[i].strobe = 8'($urandom);
        ireqs[i].is_write = 1'($urandom_range(0, 1));
      end
      oresp.ready = 1'($urandom_range(0, 1));
      oresp.last = $urandom_range(0, 2) == 0;
      oresp.data = {$urandom, $urandom};
      #1 check_cycle("rnd", mown);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
